// File: rtl/memctrl_defs.sv
// Shared definitions for the memory controller and its clients.
// The store/load buffer uses the same encodings, so the two must stay in step.
package memctrl_defs;

    // Controller sequencing states
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        DATA_RD = 2'b01,
        DATA_WR = 2'b10,
        FETCH   = 2'b11
    } state_t;

    // Direction of a data-port request, also the value driven on mem_wr
    localparam logic RAM_READ  = 1'b0;
    localparam logic RAM_WRITE = 1'b1;

    // Byte counts carried on length_from_slbuffer
    localparam logic [2:0] ZERO_LENGTH     = 3'd0;
    localparam logic [2:0] BYTE_LENGTH     = 3'd1;
    localparam logic [2:0] HALFWORD_LENGTH = 3'd2;
    localparam logic [2:0] WORD_LENGTH     = 3'd4;

    // Request-valid levels
    localparam logic TRANSMIT_ENABLE  = 1'b1;
    localparam logic TRANSMIT_DISABLE = 1'b0;

endpackage

// File: rtl/memctrl.sv
// Memory controller: serialises data-port loads/stores and instruction
// fetches onto a byte-wide single-port RAM and reassembles read data
// little-endian. The data port has priority over fetch; a flush only
// aborts an in-flight fetch.
module memctrl
    import memctrl_defs::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 3
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              transmit_from_slbuffer,
    input  logic              rw_from_slbuffer,
    input  logic [ADDR_W-1:0] addr_from_slbuffer,
    input  logic [DATA_W-1:0] data_from_slbuffer,
    input  logic [LEN_W-1:0]  length_from_slbuffer,
    output logic              data_rdy_to_slbuffer,
    output logic [DATA_W-1:0] data_to_slbuffer,
    input  logic              transmit_from_if,
    input  logic [ADDR_W-1:0] pc_from_if,
    output logic              data_rdy_to_if,
    output logic [DATA_W-1:0] inst_to_if,
    input  logic              flush_from_commit,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr
);

    state_t            state_r;
    logic [2:0]        cnt_r;        // bytes issued so far in the current access
    logic [2:0]        nbytes_r;     // byte count of the accepted request
    logic [ADDR_W-1:0] addr_r;       // latched base address
    logic [DATA_W-1:0] wdata_r;      // latched store data
    logic [DATA_W-1:0] rbuf_r;       // read assembly buffer, zero-filled

    logic [2:0]        req_n_s;      // decoded byte count of the incoming request
    logic [ADDR_W-1:0] next_addr_s;  // address of the next byte to issue
    logic [1:0]        wr_lane_s;    // lane of the next store byte
    logic [1:0]        cap_lane_s;   // lane of the byte currently on mem_din
    logic [7:0]        next_wbyte_s; // next store byte
    logic [DATA_W-1:0] cap_buf_s;    // assembly buffer with mem_din merged in
    logic              last_issue_s; // no further byte addresses to present

    // Decode the requested length; anything unsupported becomes zero bytes
    always_comb begin
        req_n_s = 3'd0;
        case (length_from_slbuffer)
            LEN_W'(ZERO_LENGTH):     req_n_s = 3'd0;
            LEN_W'(BYTE_LENGTH):     req_n_s = 3'd1;
            LEN_W'(HALFWORD_LENGTH): req_n_s = 3'd2;
            LEN_W'(WORD_LENGTH):     req_n_s = 3'd4;
            default:                 req_n_s = 3'd0;
        endcase
    end

    // Byte-lane addressing, store byte selection and read-byte merging
    always_comb begin
        next_addr_s  = addr_r + ADDR_W'(cnt_r + 3'd1);
        wr_lane_s    = 2'(cnt_r + 3'd1);
        cap_lane_s   = 2'(cnt_r - 3'd1);
        next_wbyte_s = 8'(wdata_r >> {wr_lane_s, 3'b000});
        cap_buf_s    = rbuf_r | (DATA_W'(mem_din) << {cap_lane_s, 3'b000});
        if ((cnt_r + 3'd1) >= nbytes_r) begin
            last_issue_s = 1'b1;
        end else begin
            last_issue_s = 1'b0;
        end
    end

    // Main sequencer: acceptance, byte issue, capture and completion pulses
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r              <= IDLE;
            cnt_r                <= 3'd0;
            nbytes_r             <= 3'd0;
            addr_r               <= '0;
            wdata_r              <= '0;
            rbuf_r               <= '0;
            data_rdy_to_slbuffer <= 1'b0;
            data_to_slbuffer     <= '0;
            data_rdy_to_if       <= 1'b0;
            inst_to_if           <= '0;
            mem_dout             <= 8'h00;
            mem_a                <= '0;
            mem_wr               <= 1'b0;
        end else if (rdy_in) begin
            data_rdy_to_slbuffer <= 1'b0;
            data_rdy_to_if       <= 1'b0;
            case (state_r)
                IDLE: begin
                    mem_wr <= RAM_READ;
                    if (transmit_from_slbuffer == TRANSMIT_ENABLE) begin
                        addr_r   <= addr_from_slbuffer;
                        wdata_r  <= data_from_slbuffer;
                        nbytes_r <= req_n_s;
                        cnt_r    <= 3'd0;
                        rbuf_r   <= '0;
                        if (req_n_s == 3'd0) begin
                            // Nothing to move: complete immediately with no RAM access
                            data_rdy_to_slbuffer <= 1'b1;
                            data_to_slbuffer     <= '0;
                        end else if (rw_from_slbuffer == RAM_WRITE) begin
                            mem_a    <= addr_from_slbuffer;
                            mem_dout <= data_from_slbuffer[7:0];
                            mem_wr   <= RAM_WRITE;
                            state_r  <= DATA_WR;
                        end else begin
                            mem_a   <= addr_from_slbuffer;
                            state_r <= DATA_RD;
                        end
                    end else if ((transmit_from_if != TRANSMIT_DISABLE) && !flush_from_commit) begin
                        addr_r   <= pc_from_if;
                        nbytes_r <= WORD_LENGTH;
                        cnt_r    <= 3'd0;
                        rbuf_r   <= '0;
                        mem_a    <= pc_from_if;
                        state_r  <= FETCH;
                    end
                end
                DATA_WR: begin
                    if (!last_issue_s) begin
                        mem_a    <= next_addr_s;
                        mem_dout <= next_wbyte_s;
                        mem_wr   <= RAM_WRITE;
                        cnt_r    <= cnt_r + 3'd1;
                    end else begin
                        mem_wr               <= RAM_READ;
                        data_rdy_to_slbuffer <= 1'b1;
                        data_to_slbuffer     <= '0;
                        state_r              <= IDLE;
                    end
                end
                DATA_RD, FETCH: begin
                    mem_wr <= RAM_READ;
                    if ((state_r == FETCH) && flush_from_commit) begin
                        // Speculative fetch abandoned; drop it silently
                        state_r <= IDLE;
                    end else begin
                        // mem_din carries the byte addressed one cycle earlier
                        if (cnt_r != 3'd0) begin
                            rbuf_r <= cap_buf_s;
                        end
                        if (cnt_r == nbytes_r) begin
                            state_r <= IDLE;
                            if (state_r == FETCH) begin
                                inst_to_if     <= cap_buf_s;
                                data_rdy_to_if <= 1'b1;
                            end else begin
                                data_to_slbuffer     <= cap_buf_s;
                                data_rdy_to_slbuffer <= 1'b1;
                            end
                        end else begin
                            if (!last_issue_s) begin
                                mem_a <= next_addr_s;
                            end
                            cnt_r <= cnt_r + 3'd1;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memctrl.sv
// Directed bench for memctrl with a small registered byte RAM model.
module tb_memctrl;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        transmit_from_slbuffer;
    logic        rw_from_slbuffer;
    logic [31:0] addr_from_slbuffer;
    logic [31:0] data_from_slbuffer;
    logic [2:0]  length_from_slbuffer;
    logic        data_rdy_to_slbuffer;
    logic [31:0] data_to_slbuffer;
    logic        transmit_from_if;
    logic [31:0] pc_from_if;
    logic        data_rdy_to_if;
    logic [31:0] inst_to_if;
    logic        flush_from_commit;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    logic [7:0]  ram [0:1023];

    int n_cmp  = 0;
    int n_fail = 0;

    memctrl #(.ADDR_W(32), .DATA_W(32), .LEN_W(3)) dut (
        .clk_in               (clk_in),
        .rst_in               (rst_in),
        .rdy_in               (rdy_in),
        .transmit_from_slbuffer(transmit_from_slbuffer),
        .rw_from_slbuffer     (rw_from_slbuffer),
        .addr_from_slbuffer   (addr_from_slbuffer),
        .data_from_slbuffer   (data_from_slbuffer),
        .length_from_slbuffer (length_from_slbuffer),
        .data_rdy_to_slbuffer (data_rdy_to_slbuffer),
        .data_to_slbuffer     (data_to_slbuffer),
        .transmit_from_if     (transmit_from_if),
        .pc_from_if           (pc_from_if),
        .data_rdy_to_if       (data_rdy_to_if),
        .inst_to_if           (inst_to_if),
        .flush_from_commit    (flush_from_commit),
        .mem_din              (mem_din),
        .mem_dout             (mem_dout),
        .mem_a                (mem_a),
        .mem_wr               (mem_wr)
    );

    always #5 clk_in = ~clk_in;

    // Single-port RAM: read data valid the cycle after the address, frozen by rdy_in
    always @(posedge clk_in) begin
        if (rdy_in) begin
            if (mem_wr) ram[mem_a[9:0]] <= mem_dout;
            mem_din <= ram[mem_a[9:0]];
        end
    end

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  len;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    vec_t vecs [11];

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic start_data(input logic rw, input logic [31:0] a, input logic [31:0] d, input logic [2:0] l);
        transmit_from_slbuffer = 1'b1;
        rw_from_slbuffer       = rw;
        addr_from_slbuffer     = a;
        data_from_slbuffer     = d;
        length_from_slbuffer   = l;
    endtask

    // Wait for a data-port pulse; lat is the cycle index relative to acceptance
    task automatic wait_data(inout int lat);
        while (!data_rdy_to_slbuffer && lat < 30) begin
            step();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int dcyc;
        int icyc;
        int overlap;
        int npulse;
        logic [31:0] dval;
        logic [31:0] ival;
        logic exp_wr;

        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        ram[10'h100] = 8'h11; ram[10'h101] = 8'h22; ram[10'h102] = 8'h33; ram[10'h103] = 8'h44;
        ram[10'h300] = 8'hA1; ram[10'h301] = 8'hB2; ram[10'h302] = 8'hC3; ram[10'h303] = 8'hD4;
        ram[10'h010] = 8'h5A;
        ram[10'h000] = 8'h13;
        ram[10'h080] = 8'h93; ram[10'h081] = 8'h00; ram[10'h082] = 8'h10; ram[10'h083] = 8'h00;
        ram[10'h040] = 8'h6F;
        ram[10'h3FF] = 8'h77;

        vecs[0]  = '{1'b0, 32'h0000_0100, 32'h0,          3'd4, 32'h4433_2211, 6};
        vecs[1]  = '{1'b0, 32'h0000_0302, 32'h0,          3'd2, 32'h0000_D4C3, 4};
        vecs[2]  = '{1'b0, 32'h0000_0301, 32'h0,          3'd1, 32'h0000_00B2, 3};
        vecs[3]  = '{1'b1, 32'h0000_0204, 32'hDEAD_BEEF,  3'd2, 32'h0,         3};
        vecs[4]  = '{1'b0, 32'h0000_0204, 32'h0,          3'd4, 32'h0000_BEEF, 6};
        vecs[5]  = '{1'b0, 32'h0000_0100, 32'h0,          3'd0, 32'h0,         1};
        vecs[6]  = '{1'b1, 32'h0000_0100, 32'hFFFF_FFFF,  3'd3, 32'h0,         1};
        vecs[7]  = '{1'b1, 32'h0000_0208, 32'h1234_5678,  3'd4, 32'h0,         5};
        vecs[8]  = '{1'b1, 32'h0000_020A, 32'h0000_00AA,  3'd1, 32'h0,         2};
        vecs[9]  = '{1'b0, 32'h0000_0208, 32'h0,          3'd4, 32'h12AA_5678, 6};
        vecs[10] = '{1'b0, 32'hFFFF_FFFF, 32'h0,          3'd2, 32'h0000_1377, 4};

        rst_in = 1'b1; rdy_in = 1'b1;
        transmit_from_slbuffer = 1'b0; rw_from_slbuffer = 1'b0;
        addr_from_slbuffer = 32'h0; data_from_slbuffer = 32'h0; length_from_slbuffer = 3'd0;
        transmit_from_if = 1'b0; pc_from_if = 32'h0; flush_from_commit = 1'b0;
        repeat (3) step();
        chk("rst_flags", {61'd0, data_rdy_to_slbuffer, data_rdy_to_if, mem_wr}, 64'd0);
        chk("rst_mem_a", {32'd0, mem_a}, 64'd0);
        chk("rst_data", {data_to_slbuffer, inst_to_if}, 64'd0);
        chk("rst_dout", {56'd0, mem_dout}, 64'd0);
        rst_in = 1'b0;
        step();

        // LW 0x100: byte addresses T+1..T+4, pulse at T+6, pulse one cycle wide
        start_data(1'b0, 32'h100, 32'h0, 3'd4);
        step();
        transmit_from_slbuffer = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("lw_seq_a", {32'd0, mem_a}, 64'h100 + 64'(k));
            chk("lw_seq_wr", {63'd0, mem_wr}, 64'd0);
            step();
        end
        chk("lw_seq_early", {63'd0, data_rdy_to_slbuffer}, 64'd0);
        step();
        chk("lw_seq_pulse", {63'd0, data_rdy_to_slbuffer}, 64'd1);
        chk("lw_seq_data", {32'd0, data_to_slbuffer}, 64'h4433_2211);
        step();
        chk("lw_seq_pulse_width", {63'd0, data_rdy_to_slbuffer}, 64'd0);

        // SH 0x204: bus contents per byte, pulse at T+3, neighbour untouched
        start_data(1'b1, 32'h204, 32'hDEAD_BEEF, 3'd2);
        step();
        transmit_from_slbuffer = 1'b0;
        chk("sh_b0", {23'd0, mem_wr, mem_a, mem_dout}, {23'd0, 1'b1, 32'h204, 8'hEF});
        step();
        chk("sh_b1", {23'd0, mem_wr, mem_a, mem_dout}, {23'd0, 1'b1, 32'h205, 8'hBE});
        step();
        chk("sh_pulse", {62'd0, data_rdy_to_slbuffer, mem_wr}, 64'b10);
        chk("sh_hold_a", {32'd0, mem_a}, 64'h205);
        chk("sh_ram", {40'd0, ram[10'h206], ram[10'h205], ram[10'h204]}, {40'd0, 8'h00, 8'hBE, 8'hEF});

        // Table of back-to-back data requests
        for (int i = 0; i < 11; i++) begin
            start_data(vecs[i].rw, vecs[i].addr, vecs[i].data, vecs[i].len);
            step();
            transmit_from_slbuffer = 1'b0;
            lat = 1;
            exp_wr = (vecs[i].exp_lat == 1) ? 1'b0 : vecs[i].rw;
            chk("vec_wr", {63'd0, mem_wr}, {63'd0, exp_wr});
            if (vecs[i].exp_lat != 1) chk("vec_a", {32'd0, mem_a}, {32'd0, vecs[i].addr});
            wait_data(lat);
            chk("vec_lat", 64'(lat), 64'(vecs[i].exp_lat));
            chk("vec_data", {32'd0, data_to_slbuffer}, {32'd0, vecs[i].exp_data});
        end
        step();

        // Simultaneous LB 0x10 and fetch 0x0: load first, fetch taken on the pulse cycle
        start_data(1'b0, 32'h10, 32'h0, 3'd1);
        transmit_from_if = 1'b1; pc_from_if = 32'h0;
        dcyc = 0; icyc = 0; overlap = 0; dval = 32'h0; ival = 32'h0;
        for (int c = 1; c <= 14; c++) begin
            step();
            if (c == 1) begin
                transmit_from_slbuffer = 1'b0;
                chk("prio_a", {32'd0, mem_a}, 64'h10);
            end
            if (c == 4) transmit_from_if = 1'b0;
            if (data_rdy_to_slbuffer && dcyc == 0) begin dcyc = c; dval = data_to_slbuffer; end
            if (data_rdy_to_if && icyc == 0) begin icyc = c; ival = inst_to_if; end
            if (data_rdy_to_slbuffer && data_rdy_to_if) overlap++;
        end
        chk("prio_dcyc", 64'(dcyc), 64'd3);
        chk("prio_dval", {32'd0, dval}, 64'h5A);
        chk("prio_icyc", 64'(icyc), 64'd9);
        chk("prio_ival", {32'd0, ival}, 64'h13);
        chk("prio_overlap", 64'(overlap), 64'd0);

        // Fetch 0x40 flushed at T+2: no fetch pulse, then fetch 0x80 completes
        transmit_from_if = 1'b1; pc_from_if = 32'h40;
        step();
        transmit_from_if = 1'b0;
        step();
        flush_from_commit = 1'b1;
        step();
        flush_from_commit = 1'b0;
        npulse = 0;
        for (int c = 0; c < 12; c++) begin
            if (data_rdy_to_if) npulse++;
            step();
        end
        chk("flush_no_pulse", 64'(npulse), 64'd0);
        transmit_from_if = 1'b1; pc_from_if = 32'h80;
        step();
        transmit_from_if = 1'b0;
        lat = 1;
        while (!data_rdy_to_if && lat < 30) begin step(); lat++; end
        chk("fetch_lat", 64'(lat), 64'd6);
        chk("fetch_inst", {32'd0, inst_to_if}, 64'h0010_0093);
        step();

        // Store with a flush at T+1 still completes fully
        start_data(1'b1, 32'h210, 32'hCAFE_F00D, 3'd4);
        step();
        transmit_from_slbuffer = 1'b0;
        flush_from_commit = 1'b1;
        step();
        flush_from_commit = 1'b0;
        lat = 2;
        wait_data(lat);
        chk("sw_flush_lat", 64'(lat), 64'd5);
        chk("sw_flush_ram", {32'd0, ram[10'h213], ram[10'h212], ram[10'h211], ram[10'h210]}, 64'hCAFE_F00D);
        step();

        // Reset at T+2 of an LW: outputs cleared, no pulse, then a clean LW
        start_data(1'b0, 32'h100, 32'h0, 3'd4);
        step();
        transmit_from_slbuffer = 1'b0;
        step();
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        chk("mid_rst_flags", {61'd0, data_rdy_to_slbuffer, data_rdy_to_if, mem_wr}, 64'd0);
        chk("mid_rst_a_dout", {24'd0, mem_a, mem_dout}, 64'd0);
        chk("mid_rst_data", {data_to_slbuffer, inst_to_if}, 64'd0);
        npulse = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (data_rdy_to_slbuffer || data_rdy_to_if) npulse++;
        end
        chk("mid_rst_no_pulse", 64'(npulse), 64'd0);
        start_data(1'b0, 32'h300, 32'h0, 3'd4);
        step();
        transmit_from_slbuffer = 1'b0;
        lat = 1;
        wait_data(lat);
        chk("post_rst_lat", 64'(lat), 64'd6);
        chk("post_rst_data", {32'd0, data_to_slbuffer}, 64'hD4C3_B2A1);
        step();

        // rdy_in low for three cycles mid-read stretches latency by three
        start_data(1'b0, 32'h100, 32'h0, 3'd4);
        step();
        transmit_from_slbuffer = 1'b0;
        step();
        rdy_in = 1'b0;
        step();
        step();
        chk("stall_hold_a", {31'd0, mem_wr, mem_a}, 64'h101);
        step();
        rdy_in = 1'b1;
        lat = 5;
        wait_data(lat);
        chk("stall_lat", 64'(lat), 64'd9);
        chk("stall_data", {32'd0, data_to_slbuffer}, 64'h4433_2211);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
